// File: rtl/bus_sram_slave.sv
// Single-port SRAM bus slave: decodes bursts in its window, serves read bursts and accepts write bursts.
// Latency: first read beat two cycles after begin, end-of-transaction one cycle after the last beat.
// Backpressure: none; SRAM_SLAVE_WAIT_EN inserts waitCycles idle cycles between read beats.
module bus_sram_slave #(
    parameter logic [31:0] baseAddress = 32'h4000_0000,
    parameter int          addrBits    = 10,
    parameter int          waitCycles  = 2
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        beginTransactionIn,
    input  logic [31:0] addressDataIn,
    input  logic        readNotWriteIn,
    input  logic [7:0]  burstSizeIn,
    input  logic [3:0]  byteEnablesIn,
    input  logic        dataValidIn,
    input  logic        endTransactionIn,
    output logic [31:0] addressDataOut,
    output logic        dataValidOut,
    output logic        endTransactionOut,
    output logic        busErrorOut
);

    localparam int SUM_W = ((addrBits > 9) ? addrBits : 9) + 1;

`ifdef SRAM_SLAVE_WAIT_EN
    typedef enum logic [2:0] {IDLE, DECODE, READ, READ_WAIT, READ_END, WRITE, ERROR} state_t;
`else
    typedef enum logic [2:0] {IDLE, DECODE, READ, READ_END, WRITE, ERROR} state_t;
`endif

    state_t              state;
    logic [addrBits-1:0] word_addr;
    logic [8:0]          remain;
    logic                rnw_q;
    logic [3:0]          be_q;
    logic                misalign_q;
    logic                dv_q;
    logic                eot_q;
    logic                err_q;
    logic [31:0]         rd_data;
    logic [31:0]         mem [2**addrBits];

`ifdef SRAM_SLAVE_WAIT_EN
    logic [15:0]         wait_cnt;
`else
    logic                unused_wait_cfg;
    assign unused_wait_cfg = (waitCycles != 0);
`endif

    logic             hit;
    logic [SUM_W-1:0] range_sum;
    logic             range_err;
    logic             rd_en;
    logic             wr_en;

    assign hit       = (addressDataIn[31:addrBits+2] == baseAddress[31:addrBits+2]);
    // In DECODE, remain still holds the full beat count.
    assign range_sum = SUM_W'(word_addr) + SUM_W'(remain);
    assign range_err = misalign_q || (range_sum > (SUM_W'(1) << addrBits));
    assign wr_en     = (state == WRITE) && dataValidIn && (remain != 9'd0);
    assign rd_en     = ((state == DECODE) && rnw_q && !range_err) ||
                       ((state == READ) && (remain > 9'd1));

    // The bus is OR-combined, so data is forced to zero whenever no beat is driven.
    assign addressDataOut    = dv_q ? rd_data : 32'd0;
    assign dataValidOut      = dv_q;
    assign endTransactionOut = eot_q;
    assign busErrorOut       = err_q;

    always_ff @(posedge clock) begin
        if (rd_en) begin
            rd_data <= mem[word_addr];
        end
        if (wr_en) begin
            for (int i = 0; i < 4; i++) begin
                if (be_q[i]) begin
                    mem[word_addr][8*i +: 8] <= addressDataIn[8*i +: 8];
                end
            end
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state      <= IDLE;
            word_addr  <= '0;
            remain     <= '0;
            rnw_q      <= 1'b0;
            be_q       <= '0;
            misalign_q <= 1'b0;
            dv_q       <= 1'b0;
            eot_q      <= 1'b0;
            err_q      <= 1'b0;
`ifdef SRAM_SLAVE_WAIT_EN
            wait_cnt   <= '0;
`endif
        end else begin
            dv_q  <= 1'b0;
            eot_q <= 1'b0;
            err_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (beginTransactionIn && hit) begin
                        state      <= DECODE;
                        word_addr  <= addressDataIn[addrBits+1:2];
                        remain     <= 9'(burstSizeIn) + 9'd1;
                        rnw_q      <= readNotWriteIn;
                        be_q       <= byteEnablesIn;
                        misalign_q <= (addressDataIn[1:0] != 2'b00);
                    end
                end
                DECODE: begin
                    if (range_err) begin
                        state <= ERROR;
                        err_q <= 1'b1;
                        eot_q <= 1'b1;
                    end else if (rnw_q) begin
                        state     <= READ;
                        dv_q      <= 1'b1;
                        word_addr <= word_addr + addrBits'(1);
                    end else begin
                        state <= WRITE;
                    end
                end
                READ: begin
                    if (endTransactionIn) begin
                        state <= IDLE;
                    end else if (remain == 9'd1) begin
                        state <= READ_END;
                        eot_q <= 1'b1;
                    end else begin
                        remain    <= remain - 9'd1;
                        word_addr <= word_addr + addrBits'(1);
`ifdef SRAM_SLAVE_WAIT_EN
                        if (waitCycles == 0) begin
                            dv_q <= 1'b1;
                        end else begin
                            state    <= READ_WAIT;
                            wait_cnt <= 16'(waitCycles - 1);
                        end
`else
                        dv_q <= 1'b1;
`endif
                    end
                end
`ifdef SRAM_SLAVE_WAIT_EN
                READ_WAIT: begin
                    // rd_data was fetched in the preceding READ cycle and is held until shown.
                    if (endTransactionIn) begin
                        state <= IDLE;
                    end else if (wait_cnt == 16'd0) begin
                        state <= READ;
                        dv_q  <= 1'b1;
                    end else begin
                        wait_cnt <= wait_cnt - 16'd1;
                    end
                end
`endif
                READ_END: begin
                    state <= IDLE;
                end
                WRITE: begin
                    if (wr_en) begin
                        word_addr <= word_addr + addrBits'(1);
                        remain    <= remain - 9'd1;
                    end
                    if (endTransactionIn) begin
                        state <= IDLE;
                    end
                end
                ERROR: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_bus_sram_slave.sv
// Randomized bench for bus_sram_slave against a word-array model of the SRAM window.
module tb_bus_sram_slave;

`ifdef SRAM_SLAVE_WAIT_EN
    localparam int W = 2;
`else
    localparam int W = 0;
`endif

    logic        clock = 1'b0;
    logic        reset;
    logic        beginTransactionIn;
    logic [31:0] addressDataIn;
    logic        readNotWriteIn;
    logic [7:0]  burstSizeIn;
    logic [3:0]  byteEnablesIn;
    logic        dataValidIn;
    logic        endTransactionIn;
    logic [31:0] addressDataOut;
    logic        dataValidOut;
    logic        endTransactionOut;
    logic        busErrorOut;

    always #5 clock = ~clock;

    bus_sram_slave #(
        .baseAddress(32'h4000_0000),
        .addrBits   (10),
        .waitCycles (2)
    ) dut (
        .clock             (clock),
        .reset             (reset),
        .beginTransactionIn(beginTransactionIn),
        .addressDataIn     (addressDataIn),
        .readNotWriteIn    (readNotWriteIn),
        .burstSizeIn       (burstSizeIn),
        .byteEnablesIn     (byteEnablesIn),
        .dataValidIn       (dataValidIn),
        .endTransactionIn  (endTransactionIn),
        .addressDataOut    (addressDataOut),
        .dataValidOut      (dataValidOut),
        .endTransactionOut (endTransactionOut),
        .busErrorOut       (busErrorOut)
    );

    int          n_cmp = 0;
    int          n_bad = 0;
    logic [31:0] model [1024];
    logic [31:0] wbuf [$];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic idle_inputs();
        beginTransactionIn = 1'b0;
        addressDataIn      = 32'd0;
        readNotWriteIn     = 1'b0;
        burstSizeIn        = 8'd0;
        byteEnablesIn      = 4'd0;
        dataValidIn        = 1'b0;
        endTransactionIn   = 1'b0;
    endtask

    // Cycle k = 0 is the begin cycle; outputs are checked at each falling edge before driving.
    task automatic run_xact(input logic [31:0] addr, input bit rnw, input int burst,
                            input logic [3:0] be, input int sent, input int abort_k);
        bit          hit;
        bit          err;
        int          wa;
        int          beats;
        int          eot_k;
        int          len;
        int          bi;
        logic [2:0]  ectl;
        logic [31:0] edat;
        hit   = (addr[31:12] == 20'h40000);
        wa    = int'(addr[11:2]);
        beats = burst + 1;
        err   = hit && ((addr[1:0] != 2'b00) || (wa + beats > 1024));
        eot_k = 2 + (beats - 1) * (W + 1) + 1;
        if (wbuf.size() == 0) begin
            for (int i = 0; i < sent; i++) wbuf.push_back($urandom);
        end
        len = rnw ? eot_k + 3 : 2 + sent + 3;
        if (len < 12) len = 12;
        for (int k = 0; k < len; k++) begin
            @(negedge clock);
            ectl = 3'b000;
            edat = 32'd0;
            if (hit && err) begin
                if (k == 2) ectl = 3'b110;
            end else if (hit && rnw && !(abort_k > 0 && k > abort_k)) begin
                bi = (k - 2) / (W + 1);
                if (k >= 2 && (k - 2) % (W + 1) == 0 && bi < beats) begin
                    ectl = 3'b001;
                    edat = model[wa + bi];
                end else if (k == eot_k) begin
                    ectl = 3'b010;
                end
            end
            check("ctl", {29'd0, busErrorOut, endTransactionOut, dataValidOut}, {29'd0, ectl});
            check("data", addressDataOut, edat);
            beginTransactionIn = (k == 0);
            readNotWriteIn     = rnw;
            burstSizeIn        = 8'(burst);
            byteEnablesIn      = be;
            dataValidIn        = !rnw && k >= 2 && k < 2 + sent;
            addressDataIn      = (k == 0) ? addr : (dataValidIn ? wbuf[k-2] : 32'd0);
            endTransactionIn   = (!rnw && k == 2 + sent - 1) || (rnw && abort_k > 0 && k == abort_k);
        end
        idle_inputs();
        if (hit && !err && !rnw) begin
            for (int i = 0; i < sent && i < beats; i++) begin
                for (int l = 0; l < 4; l++) begin
                    if (be[l]) model[wa+i][8*l +: 8] = wbuf[i][8*l +: 8];
                end
            end
        end
        wbuf.delete();
    endtask

    // Reset asserted while the second beat of a burst-7 read is on the bus.
    task automatic reset_mid_read();
        int k2;
        k2 = 2 + (W + 1);
        for (int k = 0; k <= k2; k++) begin
            @(negedge clock);
            if (k == k2) begin
                check("rst_pre_ctl", {29'd0, busErrorOut, endTransactionOut, dataValidOut}, 32'd1);
                check("rst_pre_data", addressDataOut, model[9]);
            end
            beginTransactionIn = (k == 0);
            addressDataIn      = (k == 0) ? 32'h4000_0020 : 32'd0;
            readNotWriteIn     = 1'b1;
            burstSizeIn        = 8'd7;
            byteEnablesIn      = 4'hF;
        end
        #2 reset = 1'b0;
        #1;
        check("rst_ctl", {29'd0, busErrorOut, endTransactionOut, dataValidOut}, 32'd0);
        check("rst_data", addressDataOut, 32'd0);
        idle_inputs();
        @(negedge clock);
        @(negedge clock);
        reset = 1'b1;
        run_xact(32'h4000_0024, 1'b1, 0, 4'hF, 0, 0);
    endtask

    initial begin
        int          sel;
        int          burst;
        bit          rnw;
        logic [31:0] addr;
        reset = 1'b0;
        idle_inputs();
        #12;
        check("reset_ctl", {29'd0, busErrorOut, endTransactionOut, dataValidOut}, 32'd0);
        check("reset_data", addressDataOut, 32'd0);
        @(negedge clock);
        reset = 1'b1;

        for (int b = 0; b < 4; b++) run_xact(32'h4000_0000 + 32'(b * 1024), 1'b0, 255, 4'hF, 256, 0);

        wbuf = '{32'h11, 32'h22, 32'h33, 32'h44};
        run_xact(32'h4000_0010, 1'b0, 3, 4'hF, 4, 0);
        run_xact(32'h4000_0010, 1'b1, 3, 4'hF, 0, 0);

        wbuf = '{32'h1234_5678};
        run_xact(32'h4000_0000, 1'b0, 0, 4'hF, 1, 0);
        wbuf = '{32'hAABB_CCDD};
        run_xact(32'h4000_0000, 1'b0, 0, 4'b0011, 1, 0);
        run_xact(32'h4000_0000, 1'b1, 0, 4'hF, 0, 0);

        run_xact(32'h4000_0FFC, 1'b1, 1, 4'hF, 0, 0);
        run_xact(32'h4000_0FFC, 1'b0, 1, 4'hF, 2, 0);
        run_xact(32'h4000_0FFC, 1'b1, 0, 4'hF, 0, 0);
        run_xact(32'h4000_0C00, 1'b1, 255, 4'hF, 0, 0);
        run_xact(32'h4000_0102, 1'b1, 2, 4'hF, 0, 0);

        run_xact(32'h2000_0000, 1'b1, 3, 4'hF, 0, 0);
        run_xact(32'h2000_0000, 1'b0, 3, 4'hF, 4, 0);

        run_xact(32'h4000_0100, 1'b0, 1, 4'hF, 4, 0);
        run_xact(32'h4000_0100, 1'b1, 3, 4'hF, 0, 0);

        run_xact(32'h4000_0200, 1'b1, 9, 4'hF, 0, 4);
        run_xact(32'h4000_0200, 1'b1, 1, 4'hF, 0, 0);

        reset_mid_read();

        for (int n = 0; n < 60; n++) begin
            sel   = $urandom_range(0, 9);
            burst = $urandom_range(0, 15);
            rnw   = $urandom_range(0, 1) == 1;
            if (sel == 0)      addr = 32'h8000_0000 | 32'($urandom_range(0, 32'hFFFF));
            else if (sel == 1) addr = 32'h4000_0000 | 32'($urandom_range(0, 4095) | 1);
            else               addr = 32'h4000_0000 | 32'($urandom_range(0, 1023) << 2);
            if (rnw)
                run_xact(addr, 1'b1, burst, 4'hF, 0,
                         ($urandom_range(0, 3) == 0) ? $urandom_range(2, 2 + burst * (W + 1)) : 0);
            else
                run_xact(addr, 1'b0, burst, 4'($urandom_range(0, 15)), $urandom_range(1, burst + 3), 0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
